// File: rtl/raabb_hit_collector.sv
// Ray/AABB hit collector: tracks issued rays through the fixed core latency,
// pairs each with its hit bit, buffers results in a FIFO and keeps statistics.
module raabb_hit_collector #(
  parameter int LATENCY    = 42,
  parameter int ID_W       = 14,
  parameter int FIFO_DEPTH = 16,
  parameter int CNT_W      = 16
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          in_valid,
  input  logic [ID_W-1:0]               in_id,
  input  logic                          hit_miss,
  input  logic                          clr_stats,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [ID_W-1:0]               out_id,
  output logic                          out_hit,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
  output logic [CNT_W-1:0]              ray_count,
  output logic [CNT_W-1:0]              hit_count,
  output logic                          overflow
);

  localparam int AW = $clog2(FIFO_DEPTH);

  logic [LATENCY-1:0] dl_v;
  logic [ID_W-1:0]    dl_id [LATENCY];

  logic            ret_v;
  logic [ID_W-1:0] ret_id;

  logic [AW:0]   wptr, rptr, wptr_n, rptr_n;
  logic [AW:0]   level;
  logic          full, push, pop, drop;
  logic [ID_W:0] mem [FIFO_DEPTH];
  logic [ID_W:0] head, head_n;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      dl_v <= '0;
    end else begin
      dl_v[0] <= in_valid;
      for (int i = 1; i < LATENCY; i++)
        dl_v[i] <= dl_v[i-1];
    end
  end

  // ids only matter alongside a set valid bit, so they need no reset
  always_ff @(posedge clk) begin
    dl_id[0] <= in_id;
    for (int i = 1; i < LATENCY; i++)
      dl_id[i] <= dl_id[i-1];
  end

  assign ret_v  = dl_v[LATENCY-1];
  assign ret_id = dl_id[LATENCY-1];

  assign level     = wptr - rptr;
  assign full      = (level == (AW+1)'(FIFO_DEPTH));
  assign out_valid = (level != '0);
  assign pop       = out_valid & out_ready;
  assign push      = ret_v & (~full | pop);
  assign drop      = ret_v & full & ~pop;
  assign rptr_n    = rptr + {{AW{1'b0}}, pop};
  assign wptr_n    = wptr + {{AW{1'b0}}, push};

  // head register tracks the entry at the next read pointer
  always_comb begin
    head_n = mem[rptr_n[AW-1:0]];
    if (rptr_n == wptr_n)
      head_n = '0;
    else if (push && (rptr_n == wptr))
      head_n = {ret_id, hit_miss};
  end

  always_ff @(posedge clk) begin
    if (push)
      mem[wptr[AW-1:0]] <= {ret_id, hit_miss};
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wptr <= '0;
      rptr <= '0;
      head <= '0;
    end else begin
      wptr <= wptr_n;
      rptr <= rptr_n;
      head <= head_n;
    end
  end

  assign out_id     = head[ID_W:1];
  assign out_hit    = head[0];
  assign fifo_level = level;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ray_count <= '0;
      hit_count <= '0;
      overflow  <= 1'b0;
    end else if (clr_stats) begin
      ray_count <= '0;
      hit_count <= '0;
      overflow  <= 1'b0;
    end else begin
      if (ret_v && (ray_count != '1))
        ray_count <= ray_count + CNT_W'(1);
      if (ret_v && hit_miss && (hit_count != '1))
        hit_count <= hit_count + CNT_W'(1);
      if (drop)
        overflow <= 1'b1;
    end
  end

endmodule
